// File: rtl/data_mem_responder_pkg.sv
// dmem_pkg: shared state encoding, lane geometry and active-low request encodings
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int BYTE_W = 8;
  localparam int LANES = 4;
  localparam logic CS_ACTIVE = 1'b0;
  localparam logic WR_STORE = 1'b0;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bundle between memory controller and data memory
interface data_mem_responder_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic cs;
  logic wr;
  logic [LANES-1:0] mask;
  logic [ADDR_W-1:0] addr;
  logic [LANES*BYTE_W-1:0] data_wr;
  logic [LANES*BYTE_W-1:0] data_rd;
  logic ready;
  logic err;
  logic busy;
  modport master (output cs, wr, mask, addr, data_wr, input data_rd, ready, err, busy);
  modport slave (input cs, wr, mask, addr, data_wr, output data_rd, ready, err, busy);
endinterface

// File: rtl/data_mem_responder_bank.sv
// dmem_bank: single-port word array with per-lane write enables and a registered read
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [LANES-1:0]        we,
  input  logic [IW-1:0]           idx,
  input  logic [LANES*BYTE_W-1:0] wdata,
  output logic [LANES*BYTE_W-1:0] rdata
);
  logic [LANES*BYTE_W-1:0] mem [DEPTH];
  // lane-masked write; a cycle with no lanes enabled is a read
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++)
        if (we[i]) mem[idx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      if (~|we) rdata <= mem[idx];
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory with programmable wait states and range checking
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT_CYCLES = 2,
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
);
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
  state_t state, next;
  logic [3:0] cnt;
  logic req_wr;
  logic [LANES-1:0] req_mask;
  logic [ADDR_W-1:0] req_addr;
  logic [LANES*BYTE_W-1:0] req_data;
  logic ready_q, err_q, busy_q, rd_zero;
  logic accept, access, in_range, is_store, bank_en;
  logic a_wr;
  logic [LANES-1:0] a_mask, bank_we;
  logic [ADDR_W-1:0] a_addr;
  logic [LANES*BYTE_W-1:0] a_data, rdata;
  // next state and access controls; a zero-wait access uses the live inputs on the accept edge
  always_comb begin
    accept = state == IDLE && bus.cs == CS_ACTIVE;
    access = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
    a_wr = state == IDLE ? bus.wr : req_wr;
    a_mask = state == IDLE ? bus.mask : req_mask;
    a_addr = state == IDLE ? bus.addr : req_addr;
    a_data = state == IDLE ? bus.data_wr : req_data;
    in_range = {2'b00, a_addr[ADDR_W-1:2]} < DEPTH_W;
    is_store = a_wr == WR_STORE;
    bank_en = access && in_range && (!is_store || |a_mask);
    bank_we = is_store ? a_mask : '0;
    next = state == IDLE ? (accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
         : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT)
         : IDLE;
  end
  // state, wait counter, latched request and registered status strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      req_wr <= 1'b1;
      req_mask <= '0;
      req_addr <= '0;
      req_data <= '0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      state <= next;
      cnt <= accept ? 4'(WAIT_CYCLES - 1) : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
      if (accept) begin
        req_wr <= bus.wr;
        req_mask <= bus.mask;
        req_addr <= bus.addr;
        req_data <= bus.data_wr;
      end
      ready_q <= next == RESP;
      busy_q <= next != IDLE;
      err_q <= access && !in_range;
      if (access) rd_zero <= !in_range ? 1'b1 : is_store ? rd_zero : 1'b0;
    end
  end
  dmem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk(clk),
    .en(bank_en),
    .we(bank_we),
    .idx(a_addr[IW+1:2]),
    .wdata(a_data),
    .rdata(rdata)
  );
  assign bus.data_rd = rd_zero ? '0 : rdata;
  assign bus.ready = ready_q;
  assign bus.err = err_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for the wait-state data memory responder
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_mem_responder_if #(.ADDR_W(32)) u0 ();
  data_mem_responder_if #(.ADDR_W(32)) u1 ();
  data_mem_responder #(.ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(u0));
  data_mem_responder #(.ADDR_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(u1));
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];
  logic [31:0] mem_m [int unsigned];
  logic [31:0] rd_m = 32'h0;
  int passed = 0;
  int total = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic xfer(input bit st, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d, input bit tog);
    exp_t e;
    int lat;
    int unsigned idx;
    logic [31:0] w;
    idx = a >> 2;
    e.err = idx >= 1024;
    if (e.err) rd_m = 32'h0;
    else if (st) begin
      w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
      for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
      mem_m[idx] = w;
    end else rd_m = mem_m[idx];
    e.data = rd_m;
    e.lat = 3;
    @(negedge clk);
    u0.cs = 1'b0;
    u0.wr = !st;
    u0.mask = m;
    u0.addr = a;
    u0.data_wr = d;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    u0.cs = 1'b1;
    lat = 1;
    while (!u0.ready && lat < 20) begin
      chk("busy_wait", {31'h0, u0.busy}, 32'h1);
      if (tog) begin
        u0.addr = $urandom;
        u0.data_wr = $urandom;
        u0.mask = 4'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    chk("ready_seen", {31'h0, u0.ready}, 32'h1);
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("data_rd", u0.data_rd, e.data);
    chk("err", {31'h0, u0.err}, {31'h0, e.err});
    chk("busy_ready", {31'h0, u0.busy}, 32'h1);
  endtask
  task automatic burst(input bit which, input int exp_n, input int exp_gap);
    int n = 0;
    int prev = -1;
    bit gap_ok = 1'b1;
    logic rdy;
    @(negedge clk);
    if (which) begin u1.cs = 1'b0; u1.wr = 1'b1; u1.addr = 32'h10; end
    else begin u0.cs = 1'b0; u0.wr = 1'b1; u0.addr = 32'h10; end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      rdy = which ? u1.ready : u0.ready;
      if (rdy) begin
        if (prev >= 0 && c - prev != exp_gap) gap_ok = 1'b0;
        prev = c;
        n++;
      end
    end
    u0.cs = 1'b1;
    u1.cs = 1'b1;
    chk(which ? "pulses_w0" : "pulses_w2", n, exp_n);
    chk(which ? "gap_w0" : "gap_w2", {31'h0, gap_ok}, 32'h1);
    if (!which) rd_m = mem_m[4];
    @(negedge clk);
  endtask
  initial begin
    int n;
    u0.cs = 1'b1; u0.wr = 1'b1; u0.mask = '0; u0.addr = '0; u0.data_wr = '0;
    u1.cs = 1'b1; u1.wr = 1'b1; u1.mask = '0; u1.addr = '0; u1.data_wr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, u0.ready}, 32'h0);
    chk("rst_err", {31'h0, u0.err}, 32'h0);
    chk("rst_busy", {31'h0, u0.busy}, 32'h0);
    chk("rst_data", u0.data_rd, 32'h0);
    rst = 1'b0;
    xfer(1, 4'hF, 32'h0, 32'h12345678, 0);
    xfer(1, 4'hF, 32'h10, 32'hDEADBEEF, 0);
    xfer(0, 4'h0, 32'h10, 32'h0, 0);
    xfer(1, 4'hF, 32'h20, 32'h11223344, 0);
    xfer(1, 4'b0100, 32'h20, 32'h00AA0000, 0);
    xfer(0, 4'h0, 32'h20, 32'h0, 0);
    xfer(1, 4'b1100, 32'h20, 32'hBBCC0000, 0);
    xfer(0, 4'h0, 32'h20, 32'h0, 0);
    xfer(1, 4'h0, 32'h20, 32'hFFFFFFFF, 0);
    xfer(0, 4'h0, 32'h20, 32'h0, 0);
    xfer(1, 4'hF, 32'h1000, 32'hA5A5A5A5, 0);
    xfer(0, 4'h0, 32'h1000, 32'h0, 0);
    xfer(0, 4'h0, 32'h0, 32'h0, 0);
    burst(0, 3, 4);
    burst(1, 6, 2);
    xfer(1, 4'hF, 32'h30, 32'h0, 0);
    @(negedge clk);
    u0.cs = 1'b0; u0.wr = 1'b0; u0.mask = 4'hF; u0.addr = 32'h30; u0.data_wr = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    u0.cs = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'h0, u0.ready}, 32'h0);
    chk("midrst_busy", {31'h0, u0.busy}, 32'h0);
    chk("midrst_err", {31'h0, u0.err}, 32'h0);
    chk("midrst_data", u0.data_rd, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_m = 32'h0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (u0.ready) n++;
    end
    chk("midrst_no_ready", n, 0);
    xfer(0, 4'h0, 32'h30, 32'h0, 0);
    xfer(1, 4'hF, 32'h40, 32'hCAFEF00D, 1);
    xfer(0, 4'h0, 32'h40, 32'h0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
